param_register_file: RTL and testbench

- Parametrised successor to the CPU's 2-read/1-write register file: configurable data width and depth, byte-lane write enables, optional hardwired zero register, and asynchronous clear.
- Adds a per-register busy scoreboard so the multi-cycle/pipelined controller can detect pending writes to source registers.
- Sits in the datapath between decode (A1/A2/A3) and writeback (WD3).

---
 rtl/param_register_file.sv | 137 +++++++++++++
 tb/tb_param_register_file.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/param_register_file.sv
// Purpose : parametrised 2-read/1-write register file with byte-lane writes and a per-register busy scoreboard.
// Latency : reads and busy lookups are combinational (0 cycles); writes and busy updates land on the rising edge.
// Backpressure: none; every write/busySet strobe is accepted on the edge it is presented.
//
// Ports:
//   clk, rst_n        rising-edge clock; asynchronous active-low clear of data and busy bits
//   A1/A2 -> RD1/RD2  read addresses and read data
//   RD1busy/RD2busy   pending-write flag for A1/A2
//   A3, WD3, writeEN, BE  write port with byte-lane enables (BE[i] covers WD3[8i+7:8i])
//   busySet, busyAddr mark a register as having a pending write
//   anyBusy           OR of every busy bit
//
// Optional macro REGFILE_BYPASS_EN: write-first forwarding of a same-cycle write to the read ports.
// Without it the read ports show stored state only (read-before-write).

module param_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   A1,
  input  logic [ADDR_WIDTH-1:0]   A2,
  input  logic [ADDR_WIDTH-1:0]   A3,
  input  logic [DATA_WIDTH-1:0]   WD3,
  input  logic                    writeEN,
  input  logic [DATA_WIDTH/8-1:0] BE,
  input  logic                    busySet,
  input  logic [ADDR_WIDTH-1:0]   busyAddr,
  output logic [DATA_WIDTH-1:0]   RD1,
  output logic [DATA_WIDTH-1:0]   RD2,
  output logic                    RD1busy,
  output logic                    RD2busy,
  output logic                    anyBusy
);

  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam int NBYTES   = DATA_WIDTH / 8;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] rd1_stored;
  logic [DATA_WIDTH-1:0] rd2_stored;
  logic [DATA_WIDTH-1:0] rd1_val;
  logic [DATA_WIDTH-1:0] rd2_val;
  logic                  rd1_busy_val;
  logic                  rd2_busy_val;

  // Writes to the hardwired zero register are dropped entirely.
  assign wr_ok = writeEN && !(HAS_ZERO && (A3 == '0));

  // Data array: only enabled byte lanes are updated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (BE[b]) begin
          mem[A3][8*b +: 8] <= WD3[8*b +: 8];
        end
      end
    end
  end

  // Scoreboard update. The set is applied after the clear so that a new
  // producer issued on the same edge as the old one's writeback stays pending.
  // A write clears busy even with BE=0: the producer has retired either way.
  always_comb begin
    busy_nxt = busy;
    if (writeEN) begin
      busy_nxt[A3] = 1'b0;
    end
    if (busySet) begin
      busy_nxt[busyAddr] = 1'b1;
    end
    if (HAS_ZERO) begin
      busy_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign rd1_stored = (HAS_ZERO && (A1 == '0)) ? '0 : mem[A1];
  assign rd2_stored = (HAS_ZERO && (A2 == '0)) ? '0 : mem[A2];

`ifdef REGFILE_BYPASS_EN
  logic [DATA_WIDTH-1:0] wr_merged;
  logic                  hit1;
  logic                  hit2;

  // Value the target register will hold after this edge.
  always_comb begin
    wr_merged = mem[A3];
    for (int b = 0; b < NBYTES; b++) begin
      if (BE[b]) begin
        wr_merged[8*b +: 8] = WD3[8*b +: 8];
      end
    end
  end

  // wr_ok already excludes the zero register, so it never forwards.
  assign hit1 = wr_ok && (A1 == A3);
  assign hit2 = wr_ok && (A2 == A3);

  assign rd1_val      = hit1 ? wr_merged : rd1_stored;
  assign rd2_val      = hit2 ? wr_merged : rd2_stored;
  // A forwarded read is no longer pending unless a new producer targets it now.
  assign rd1_busy_val = hit1 ? (busySet && (busyAddr == A1)) : busy[A1];
  assign rd2_busy_val = hit2 ? (busySet && (busyAddr == A2)) : busy[A2];
`else
  assign rd1_val      = rd1_stored;
  assign rd2_val      = rd2_stored;
  assign rd1_busy_val = busy[A1];
  assign rd2_busy_val = busy[A2];
`endif

  // Hold every output at zero while reset is asserted, including any
  // forwarded write data presented during reset.
  assign RD1     = rst_n ? rd1_val : '0;
  assign RD2     = rst_n ? rd2_val : '0;
  assign RD1busy = rst_n & rd1_busy_val;
  assign RD2busy = rst_n & rd2_busy_val;
  assign anyBusy = |busy;

endmodule

// File: tb/tb_param_register_file.sv
module tb_param_register_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  A1, A2, A3, busyAddr;
  logic [31:0] WD3;
  logic        writeEN, busySet;
  logic [3:0]  BE;
  logic [31:0] RD1, RD2;
  logic        RD1busy, RD2busy, anyBusy;

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  param_register_file dut (
    .clk(clk), .rst_n(rst_n),
    .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
    .writeEN(writeEN), .BE(BE),
    .busySet(busySet), .busyAddr(busyAddr),
    .RD1(RD1), .RD2(RD2),
    .RD1busy(RD1busy), .RD2busy(RD2busy), .anyBusy(anyBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    writeEN = 1'b0;
    busySet = 1'b0;
    BE      = 4'h0;
    WD3     = 32'h0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    A3 = a; WD3 = d; BE = be; writeEN = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    A1 = 5'd0; A2 = 5'd0; A3 = 5'd0; busyAddr = 5'd0;
    idle();
    #12;
    checks++; if (RD1 !== 32'h0) begin errors++; $display("FAIL reset_rd1: got %h want %h", RD1, 32'h0); end
    checks++; if (RD2 !== 32'h0) begin errors++; $display("FAIL reset_rd2: got %h want %h", RD2, 32'h0); end
    checks++; if ({RD1busy, RD2busy, anyBusy} !== 3'b000)
      begin errors++; $display("FAIL reset_busy: got %b want 000", {RD1busy, RD2busy, anyBusy}); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    do_write(5'd2, 32'h12345678, 4'hF);
    A1 = 5'd2; #1;
    checks++; if (RD1 !== 32'h12345678) begin errors++; $display("FAIL wr_full: got %h want %h", RD1, 32'h12345678); end
    A3 = 5'd10; WD3 = 32'hDEADBEEF; BE = 4'hF; writeEN = 1'b0;
    tick();
    A2 = 5'd10; #1;
    checks++; if (RD2 !== 32'h0) begin errors++; $display("FAIL wr_disabled: got %h want %h", RD2, 32'h0); end
  endtask

  task automatic test_zero_reg();
    A1 = 5'd0;
    do_write(5'd0, 32'hFFFFFFFF, 4'hF);
    #1;
    checks++; if (RD1 !== 32'h0) begin errors++; $display("FAIL zero_data: got %h want %h", RD1, 32'h0); end
    busySet = 1'b1; busyAddr = 5'd0;
    tick();
    idle(); #1;
    checks++; if (RD1busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", RD1busy); end
    checks++; if (anyBusy !== 1'b0) begin errors++; $display("FAIL zero_anybusy: got %b want 0", anyBusy); end
  endtask

  task automatic test_byte_lanes();
    do_write(5'd5, 32'h87654321, 4'hF);
    do_write(5'd5, 32'hAABBCCDD, 4'b0101);
    A1 = 5'd5; #1;
    checks++; if (RD1 !== 32'h87BB43DD) begin errors++; $display("FAIL byte_lanes: got %h want %h", RD1, 32'h87BB43DD); end
    do_write(5'd5, 32'hFFFFFFFF, 4'b0000);
    #1;
    checks++; if (RD1 !== 32'h87BB43DD) begin errors++; $display("FAIL be_zero: got %h want %h", RD1, 32'h87BB43DD); end
    do_write(5'd5, 32'h11223344, 4'b1000);
    #1;
    checks++; if (RD1 !== 32'h11BB43DD) begin errors++; $display("FAIL byte_top: got %h want %h", RD1, 32'h11BB43DD); end
  endtask

  task automatic test_scoreboard();
    busySet = 1'b1; busyAddr = 5'd7;
    tick();
    idle();
    A2 = 5'd7; A1 = 5'd9; #1;
    checks++; if (RD2busy !== 1'b1) begin errors++; $display("FAIL sb_set: got %b want 1", RD2busy); end
    checks++; if (anyBusy !== 1'b1) begin errors++; $display("FAIL sb_any: got %b want 1", anyBusy); end
    checks++; if (RD1busy !== 1'b0) begin errors++; $display("FAIL sb_other: got %b want 0", RD1busy); end
    // Writeback presented: forwarded reads drop busy before the edge.
    A3 = 5'd7; WD3 = 32'h0; BE = 4'h0; writeEN = 1'b1; #1;
    checks++; if (RD2busy !== !BYP) begin errors++; $display("FAIL sb_pre_clear: got %b want %b", RD2busy, !BYP); end
    tick();
    idle(); #1;
    checks++; if (RD2busy !== 1'b0) begin errors++; $display("FAIL sb_clear: got %b want 0", RD2busy); end
    checks++; if (anyBusy !== 1'b0) begin errors++; $display("FAIL sb_any_clear: got %b want 0", anyBusy); end
    // Same-edge set and clear on reg 7: set wins.
    busySet = 1'b1; busyAddr = 5'd7; A3 = 5'd7; writeEN = 1'b1; BE = 4'h0; #1;
    checks++; if (RD2busy !== BYP) begin errors++; $display("FAIL sb_pre_both: got %b want %b", RD2busy, BYP); end
    tick();
    idle(); #1;
    checks++; if (RD2busy !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b want 1", RD2busy); end
    // Port 1 lookup of a different register.
    busySet = 1'b1; busyAddr = 5'd9;
    tick();
    idle(); #1;
    checks++; if (RD1busy !== 1'b1) begin errors++; $display("FAIL sb_port1: got %b want 1", RD1busy); end
    A3 = 5'd7; writeEN = 1'b1; tick(); idle();
    A3 = 5'd9; writeEN = 1'b1; tick(); idle(); #1;
    checks++; if (anyBusy !== 1'b0) begin errors++; $display("FAIL sb_drain: got %b want 0", anyBusy); end
  endtask

  task automatic test_bypass();
    A1 = 5'd25; A3 = 5'd25; WD3 = 32'h81010014; BE = 4'hF; writeEN = 1'b1; #1;
    checks++; if (RD1 !== (BYP ? 32'h81010014 : 32'h0))
      begin errors++; $display("FAIL byp_pre: got %h want %h", RD1, (BYP ? 32'h81010014 : 32'h0)); end
    tick();
    idle(); #1;
    checks++; if (RD1 !== 32'h81010014) begin errors++; $display("FAIL byp_post: got %h want %h", RD1, 32'h81010014); end
    A2 = 5'd25; A3 = 5'd25; WD3 = 32'hFFFFFFFF; BE = 4'b0010; writeEN = 1'b1; #1;
    checks++; if (RD2 !== (BYP ? 32'h8101FF14 : 32'h81010014))
      begin errors++; $display("FAIL byp_merge: got %h want %h", RD2, (BYP ? 32'h8101FF14 : 32'h81010014)); end
    tick();
    idle(); #1;
    checks++; if (RD2 !== 32'h8101FF14) begin errors++; $display("FAIL byp_merge_post: got %h want %h", RD2, 32'h8101FF14); end
  endtask

  task automatic test_async_reset();
    do_write(5'd2, 32'h11111111, 4'hF);
    do_write(5'd10, 32'h22222222, 4'hF);
    busySet = 1'b1; busyAddr = 5'd3;
    tick();
    idle();
    A1 = 5'd2; A2 = 5'd10; #1;
    checks++; if (RD1 !== 32'h11111111) begin errors++; $display("FAIL ar_pre_rd1: got %h want %h", RD1, 32'h11111111); end
    checks++; if (anyBusy !== 1'b1) begin errors++; $display("FAIL ar_pre_any: got %b want 1", anyBusy); end
    #1 rst_n = 1'b0; #1;
    checks++; if (RD1 !== 32'h0) begin errors++; $display("FAIL ar_rd1: got %h want %h", RD1, 32'h0); end
    checks++; if (RD2 !== 32'h0) begin errors++; $display("FAIL ar_rd2: got %h want %h", RD2, 32'h0); end
    checks++; if (anyBusy !== 1'b0) begin errors++; $display("FAIL ar_any: got %b want 0", anyBusy); end
    #1 rst_n = 1'b1;
    tick(); #1;
    checks++; if (RD1 !== 32'h0) begin errors++; $display("FAIL ar_post_rd1: got %h want %h", RD1, 32'h0); end
    checks++; if (RD2 !== 32'h0) begin errors++; $display("FAIL ar_post_rd2: got %h want %h", RD2, 32'h0); end
    A1 = 5'd3; #1;
    checks++; if (RD1busy !== 1'b0) begin errors++; $display("FAIL ar_post_busy: got %b want 0", RD1busy); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_byte_lanes();
    test_scoreboard();
    test_bypass();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
